// File: rtl/kv_pkg.sv
// Shared definitions for the two-table key/value lookup: widths, entry layout,
// controller state encoding and the two table hash functions.
package kv_pkg;

    localparam int KEY_WIDTH    = 16;
    localparam int VAL_WIDTH    = 9;
    localparam int H1_ADDR_BITS = 3;
    localparam int H2_ADDR_BITS = 4;
    localparam int ENTRY_WIDTH  = 1 + KEY_WIDTH + VAL_WIDTH;
    localparam int STAT_WIDTH   = 16;

    // Entry layout: {valid, key, value_addr}, valid in the MSB.
    localparam int ENT_VALID_BIT = ENTRY_WIDTH - 1;
    localparam int ENT_KEY_LSB   = VAL_WIDTH;
    localparam int ENT_VAL_LSB   = 0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD1  = 3'd1,
        ST_CMP1 = 3'd2,
        ST_RD2  = 3'd3,
        ST_CMP2 = 3'd4,
        ST_RESP = 3'd5
    } kv_state_e;

    function automatic logic [H1_ADDR_BITS-1:0] kv_hash1(input logic [KEY_WIDTH-1:0] key);
        return key[H1_ADDR_BITS-1:0];
    endfunction

    // Fold the next nibble into the index so keys sharing low bits spread across table 2.
    function automatic logic [H2_ADDR_BITS-1:0] kv_hash2(input logic [KEY_WIDTH-1:0] key);
        logic [KEY_WIDTH-1:0] mix;
        mix = key ^ (key >> H2_ADDR_BITS);
        return mix[H2_ADDR_BITS-1:0];
    endfunction

    function automatic logic ent_valid(input logic [ENTRY_WIDTH-1:0] e);
        return e[ENT_VALID_BIT];
    endfunction

    function automatic logic [KEY_WIDTH-1:0] ent_key(input logic [ENTRY_WIDTH-1:0] e);
        return e[ENT_KEY_LSB +: KEY_WIDTH];
    endfunction

    function automatic logic [VAL_WIDTH-1:0] ent_val(input logic [ENTRY_WIDTH-1:0] e);
        return e[ENT_VAL_LSB +: VAL_WIDTH];
    endfunction

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (v == {STAT_WIDTH{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/kv_rr_arb2.sv
// Two-input round-robin arbiter; on a tie the requester not granted last wins.
// last_q resets to 1 so requester 0 takes the first tie.
module kv_rr_arb2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req_i,
    input  logic       en_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    logic last_q;
    logic [1:0] pick;

    always_comb begin
        pick = req_i;
        if (req_i == 2'b11) begin
            pick = last_q ? 2'b01 : 2'b10;
        end
    end

    assign grant_o = en_i ? pick : 2'b00;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else if (accept_i) begin
            last_q <= grant_o[1];
        end
    end

endmodule

// File: rtl/kv_lookup_ctrl.sv
// Lookup sequencer: arbitrates two requesters, probes table 1 then table 2, returns hit/miss.
// Define KV_LOOKUP_STATS_EN to add saturating hit1/hit2/miss counters as output ports.
//
// state | meaning
// IDLE  | waiting for a request, req_ready driven by the arbiter
// RD1   | table 1 read issued (h1_en high for this cycle only)
// CMP1  | table 1 entry returned, compare against latched key
// RD2   | table 2 read issued (h2_en high for this cycle only)
// CMP2  | table 2 entry returned, compare against latched key
// RESP  | response held until rsp_ready
module kv_lookup_ctrl
    import kv_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [1:0]               req_valid,
    input  logic [2*KEY_WIDTH-1:0]   req_key,
    output logic [1:0]               req_ready,
    output logic                     h1_en,
    output logic [H1_ADDR_BITS-1:0]  h1_addr,
    input  logic [ENTRY_WIDTH-1:0]   h1_rdata,
    output logic                     h2_en,
    output logic [H2_ADDR_BITS-1:0]  h2_addr,
    input  logic [ENTRY_WIDTH-1:0]   h2_rdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_id,
    output logic                     rsp_hit,
    output logic                     rsp_table,
    output logic [VAL_WIDTH-1:0]     rsp_value_addr
`ifdef KV_LOOKUP_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]    stat_hit1,
    output logic [STAT_WIDTH-1:0]    stat_hit2,
    output logic [STAT_WIDTH-1:0]    stat_miss
`endif
);

    kv_state_e                state_q;
    logic [KEY_WIDTH-1:0]     key_q;
    logic                     id_q;
    logic                     h1_en_q;
    logic [H1_ADDR_BITS-1:0]  h1_addr_q;
    logic                     h2_en_q;
    logic [H2_ADDR_BITS-1:0]  h2_addr_q;
    logic                     rsp_valid_q;
    logic                     rsp_id_q;
    logic                     rsp_hit_q;
    logic                     rsp_table_q;
    logic [VAL_WIDTH-1:0]     rsp_value_addr_q;

    logic                     arb_en;
    logic [1:0]               grant;
    logic [1:0]               accept;
    logic [KEY_WIDTH-1:0]     sel_key;
    logic                     hit1;
    logic                     hit2;

    // Gating with reset_n keeps req_ready low while reset is held, even though IDLE is the reset state.
    assign arb_en = reset_n && (state_q == ST_IDLE);

    kv_rr_arb2 u_arb (
        .clock    (clock),
        .reset_n  (reset_n),
        .req_i    (req_valid),
        .en_i     (arb_en),
        .accept_i (|accept),
        .grant_o  (grant)
    );

    assign req_ready = grant;
    assign accept    = req_valid & grant;
    assign sel_key   = grant[1] ? req_key[KEY_WIDTH +: KEY_WIDTH] : req_key[0 +: KEY_WIDTH];

    assign hit1 = ent_valid(h1_rdata) && (ent_key(h1_rdata) == key_q);
    assign hit2 = ent_valid(h2_rdata) && (ent_key(h2_rdata) == key_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            key_q            <= '0;
            id_q             <= 1'b0;
            h1_en_q          <= 1'b0;
            h1_addr_q        <= '0;
            h2_en_q          <= 1'b0;
            h2_addr_q        <= '0;
            rsp_valid_q      <= 1'b0;
            rsp_id_q         <= 1'b0;
            rsp_hit_q        <= 1'b0;
            rsp_table_q      <= 1'b0;
            rsp_value_addr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|accept) begin
                        key_q     <= sel_key;
                        id_q      <= grant[1];
                        h1_en_q   <= 1'b1;
                        h1_addr_q <= kv_hash1(sel_key);
                        state_q   <= ST_RD1;
                    end
                end
                ST_RD1: begin
                    h1_en_q   <= 1'b0;
                    h1_addr_q <= '0;
                    state_q   <= ST_CMP1;
                end
                ST_CMP1: begin
                    if (hit1) begin
                        rsp_valid_q      <= 1'b1;
                        rsp_id_q         <= id_q;
                        rsp_hit_q        <= 1'b1;
                        rsp_table_q      <= 1'b0;
                        rsp_value_addr_q <= ent_val(h1_rdata);
                        state_q          <= ST_RESP;
                    end else begin
                        h2_en_q   <= 1'b1;
                        h2_addr_q <= kv_hash2(key_q);
                        state_q   <= ST_RD2;
                    end
                end
                ST_RD2: begin
                    h2_en_q   <= 1'b0;
                    h2_addr_q <= '0;
                    state_q   <= ST_CMP2;
                end
                ST_CMP2: begin
                    rsp_valid_q      <= 1'b1;
                    rsp_id_q         <= id_q;
                    rsp_hit_q        <= hit2;
                    rsp_table_q      <= hit2;
                    rsp_value_addr_q <= hit2 ? ent_val(h2_rdata) : '0;
                    state_q          <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    h1_en_q     <= 1'b0;
                    h2_en_q     <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign h1_en          = h1_en_q;
    assign h1_addr        = h1_addr_q;
    assign h2_en          = h2_en_q;
    assign h2_addr        = h2_addr_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_id         = rsp_id_q;
    assign rsp_hit        = rsp_hit_q;
    assign rsp_table      = rsp_table_q;
    assign rsp_value_addr = rsp_value_addr_q;

`ifdef KV_LOOKUP_STATS_EN
    logic [STAT_WIDTH-1:0] stat_hit1_q;
    logic [STAT_WIDTH-1:0] stat_hit2_q;
    logic [STAT_WIDTH-1:0] stat_miss_q;
    logic                  rsp_fire;

    assign rsp_fire = rsp_valid_q && rsp_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_hit1_q <= '0;
            stat_hit2_q <= '0;
            stat_miss_q <= '0;
        end else if (rsp_fire) begin
            if (!rsp_hit_q) begin
                stat_miss_q <= sat_inc(stat_miss_q);
            end else if (rsp_table_q) begin
                stat_hit2_q <= sat_inc(stat_hit2_q);
            end else begin
                stat_hit1_q <= sat_inc(stat_hit1_q);
            end
        end
    end

    assign stat_hit1 = stat_hit1_q;
    assign stat_hit2 = stat_hit2_q;
    assign stat_miss = stat_miss_q;
`endif

endmodule

// File: doc/kv_lookup_ctrl.md
# kv_lookup_ctrl

Lookup sequencer and arbiter for the two-table (hash1/hash2) key-value store. It accepts key lookups from two requesters, arbitrates round-robin, and probes hash table 1 then hash table 2 through their synchronous BRAM read ports. It returns hit/miss with the stored value address on a single shared response channel. It sits between the query sources and the BRAMs built by create_bram, and replaces direct ram_enable/key driving.

## Interface
- KEY_WIDTH, 16: key width in bits.
- VAL_WIDTH, 9: value address width, equal to RAM_ADDR_BITS of the key/value store.
- H1_ADDR_BITS, 3: hash table 1 index width.
- H2_ADDR_BITS, 4: hash table 2 index width.
- ENTRY_WIDTH, 1+KEY_WIDTH+VAL_WIDTH: table entry, {valid, key, value_addr}, valid is the MSB.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester lookup request (bit i = requester i).
- req_key  in  2*KEY_WIDTH  requester i key in slice [i*KEY_WIDTH +: KEY_WIDTH].
- req_ready  out  2  one-hot grant; a request is accepted when req_valid[i] & req_ready[i].
- h1_en  out  1  table 1 read enable.
- h1_addr  out  H1_ADDR_BITS  table 1 read index.
- h1_rdata  in  ENTRY_WIDTH  table 1 entry, valid 1 cycle after h1_en.
- h2_en, h2_addr, h2_rdata: same as h1_*, for table 2 (H2_ADDR_BITS wide).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_id  out  1  requester that owns the response.
- rsp_hit  out  1  1 = key found.
- rsp_table  out  1  0 = hit in table 1, 1 = hit in table 2; 0 on a miss.
- rsp_value_addr  out  VAL_WIDTH  stored value address on a hit, 0 on a miss.

## Operation
- States: IDLE, RD1, CMP1, RD2, CMP2, RESP.
- IDLE: req_ready is combinational and one-hot for the selected requester, 0 if neither is valid.
  - Only one requester valid: select it.
  - Both valid: select the requester not granted last. Priority pointer last_grant, reset value 1, so requester 0 wins the first tie.
  - On accept: latch key and id, update last_grant, go to RD1.
- Hash 1: h1 = key[H1_ADDR_BITS-1:0].
- Hash 2: h2 = (key ^ (key >> H2_ADDR_BITS))[H2_ADDR_BITS-1:0].
- Both hashes are computed from the latched key, zero-extended as needed.
- RD1: h1_en=1, h1_addr=h1; go to CMP1.
- CMP1: hit if h1_rdata valid bit = 1 and the stored key equals the latched key.
  - Hit: capture value and table=0; go to RESP.
  - Otherwise: go to RD2.
- RD2/CMP2: same sequence on table 2.
  - Hit: capture value and table=1.
  - Miss: hit=0, value=0, table=0.
  - Either way, go to RESP.
- RESP: rsp_valid=1 with all response fields stable. On rsp_ready, go to IDLE. Hold indefinitely while rsp_ready=0.
- No request is accepted outside IDLE. req_ready=0 in every other state.

## Timing
- Reset values: req_ready=0, h1_en=h2_en=0, h1_addr=h2_addr=0, rsp_valid=0, rsp_id=0, rsp_hit=0, rsp_table=0, rsp_value_addr=0; state IDLE.
- Latency from the accept edge (cycle 0) to rsp_valid high:
  - Table 1 hit: 3 cycles.
  - Table 2 hit or miss: 5 cycles.
- The response handshake completes in the same cycle as rsp_ready. The next accept can occur in the following cycle, so minimum request spacing is 4 cycles (hit) or 6 cycles (miss).
- h*_en is high for exactly one cycle per probe. The read address is held only during the RD cycle.
- A key present in both tables reports table 1, because table 1 is probed first.
- Entries with valid=0 never match, even when the key bits are equal.
- Reset asserted mid-lookup aborts it asynchronously: no response is produced, all outputs take their reset values, and last_grant returns to 1.
- A requester that drops req_valid before it is granted is simply not served. No request state is retained.

## Configuration
- KV_LOOKUP_STATS_EN defined:
  - Adds three 16-bit saturating counters: stat_hit1, stat_hit2, stat_miss.
  - Each increments on the RESP handshake matching its outcome.
  - Counters reset to 0 and are exposed as output ports.
- KV_LOOKUP_STATS_EN undefined: the counters and their ports do not exist. All other behaviour is identical.

## Structure
- Shared package kv_pkg:
  - state encoding.
  - entry field offsets (valid bit, key slice, value slice).
  - hash-function definitions, reused by the table-builder and the bench.
- One sub-module, kv_rr_arb2: a 2-input round-robin arbiter with a last_grant register. The FSM, hashing and compare logic stay in kv_lookup_ctrl.

## Test plan
- Table 1 index 7 = {1, 175, 9'd42}; requester 0 sends key 175 → rsp_valid 3 cycles after accept, rsp_id=0, rsp_hit=1, rsp_table=0, rsp_value_addr=42, h2_en never asserted.
- Table 1 index 0 holds a different key; table 2 index 14 = {1, 104, 9'd300}; key 104 → rsp after 5 cycles, rsp_hit=1, rsp_table=1, rsp_value_addr=300.
- Key 175 with table 1 entry valid=0 and no table 2 match → rsp_hit=0, rsp_table=0, rsp_value_addr=0 after 5 cycles.
- Both requesters valid continuously for 4 lookups → grants in order 0,1,0,1, with rsp_id matching each grant.
- Hold rsp_ready=0 for 10 cycles → rsp fields stable, req_ready=0 throughout; rsp_ready=1 → IDLE the next cycle.
- Assert reset_n=0 during CMP1 → all outputs 0 immediately, no response produced; after release, the first tie is granted to requester 0.
